// File: rtl/down_counter4b.sv
// Loadable down-counter/timer with one-shot and auto-reload modes.
// Emits a single-cycle terminal-count pulse when the count expires.
module down_counter4b #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             reload,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [1:0]       state;
    logic [WIDTH-1:0] reload_r;
    logic             mode_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            reload_r <= '0;
            mode_r   <= 1'b0;
            tc       <= 1'b0;
        end else if (load) begin
            reload_r <= load_val;
            mode_r   <= reload;
            cnt      <= load_val;
            tc       <= 1'b0;
            state    <= (load_val != '0) ? RUN : IDLE;
        end else begin
            tc <= 1'b0;
            case (state)
                RUN: begin
                    // RUN always holds cnt >= 1, so the decrement never wraps
                    if (en) begin
                        if (cnt == ONE) begin
                            tc <= 1'b1;
                            if (mode_r) begin
                                cnt <= reload_r;
                            end else begin
                                cnt   <= '0;
                                state <= DONE;
                            end
                        end else begin
                            cnt <= cnt - ONE;
                        end
                    end
                end
                IDLE, DONE: begin
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_down_counter4b.sv
// Directed and model-based checks for down_counter4b.
module tb_down_counter4b;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [3:0] load_val;
    logic       reload;
    logic       en;
    logic [3:0] cnt;
    logic       tc;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;

    down_counter4b #(.WIDTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .load_val(load_val),
        .reload(reload),
        .en(en),
        .cnt(cnt),
        .tc(tc),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] v, input logic m);
        load = 1'b1;
        load_val = v;
        reload = m;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; load_val = '0; reload = 1'b0; en = 1'b0;
        tick();
        tests++;
        if ({cnt, tc, busy, done} !== 7'b0) begin
            fails++;
            $display("FAIL reset_init got cnt=%0d tc=%b busy=%b done=%b want 0 0 0 0",
                     cnt, tc, busy, done);
        end
        rst = 1'b0;
        do_load(4'd8, 1'b0);
        en = 1'b1;
        repeat (3) tick();
        tests++;
        if (cnt !== 4'd5 || busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_precount got cnt=%0d busy=%b want 5 1", cnt, busy);
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if ({cnt, tc, busy, done} !== 7'b0) begin
                fails++;
                $display("FAIL reset_mid%0d got cnt=%0d tc=%b busy=%b done=%b want 0 0 0 0",
                         i, cnt, tc, busy, done);
            end
        end
        rst = 1'b0;
        // rst on the would-be terminal edge suppresses tc
        do_load(4'd1, 1'b0);
        rst = 1'b1;
        tick();
        tests++;
        if (tc !== 1'b0 || done !== 1'b0 || cnt !== 4'd0) begin
            fails++;
            $display("FAIL reset_tc got tc=%b done=%b cnt=%0d want 0 0 0", tc, done, cnt);
        end
        rst = 1'b0;
        en = 1'b0;
    endtask

    task automatic test_oneshot();
        logic [3:0] exp;
        do_load(4'd5, 1'b0);
        tests++;
        if (cnt !== 4'd5 || busy !== 1'b1 || tc !== 1'b0) begin
            fails++;
            $display("FAIL oneshot_load got cnt=%0d busy=%b tc=%b want 5 1 0", cnt, busy, tc);
        end
        en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            exp = 4'(5 - i);
            tests++;
            if (cnt !== exp || tc !== (i == 5)) begin
                fails++;
                $display("FAIL oneshot_step%0d got cnt=%0d tc=%b want %0d %b",
                         i, cnt, tc, exp, (i == 5));
            end
        end
        tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL oneshot_done got done=%b busy=%b want 1 0", done, busy);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++;
            if (cnt !== 4'd0 || tc !== 1'b0 || done !== 1'b1) begin
                fails++;
                $display("FAIL oneshot_hold%0d got cnt=%0d tc=%b done=%b want 0 0 1",
                         i, cnt, tc, done);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_autoreload();
        logic [3:0] seq [3] = '{4'd2, 4'd1, 4'd3};
        do_load(4'd3, 1'b1);
        en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            tests++;
            if (cnt !== seq[i % 3] || tc !== (i % 3 == 2) || busy !== 1'b1) begin
                fails++;
                $display("FAIL auto3_step%0d got cnt=%0d tc=%b busy=%b want %0d %b 1",
                         i, cnt, tc, busy, seq[i % 3], (i % 3 == 2));
            end
        end
        do_load(4'd1, 1'b1);
        tests++;
        if (tc !== 1'b0 || cnt !== 4'd1) begin
            fails++;
            $display("FAIL auto1_load got cnt=%0d tc=%b want 1 0", cnt, tc);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (cnt !== 4'd1 || tc !== 1'b1 || busy !== 1'b1) begin
                fails++;
                $display("FAIL auto1_step%0d got cnt=%0d tc=%b busy=%b want 1 1 1",
                         i, cnt, tc, busy);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_en_gaps();
        logic       pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [3:0] exp [7] = '{4'd3, 4'd3, 4'd3, 4'd2, 4'd1, 4'd1, 4'd0};
        do_load(4'd4, 1'b0);
        for (int i = 0; i < 7; i++) begin
            en = pat[i];
            reload = ~reload;
            load_val = 4'(i + 7);
            tick();
            tests++;
            if (cnt !== exp[i] || tc !== (i == 6)) begin
                fails++;
                $display("FAIL gaps_step%0d got cnt=%0d tc=%b want %0d %b",
                         i, cnt, tc, exp[i], (i == 6));
            end
        end
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL gaps_done got done=%b want 1", done);
        end
        en = 1'b0;
    endtask

    task automatic test_collision();
        do_load(4'd2, 1'b0);
        en = 1'b1;
        tick();
        tests++;
        if (cnt !== 4'd1) begin
            fails++;
            $display("FAIL coll_pre got cnt=%0d want 1", cnt);
        end
        do_load(4'd9, 1'b0);
        tests++;
        if (cnt !== 4'd9 || tc !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL coll_load9 got cnt=%0d tc=%b busy=%b want 9 0 1", cnt, tc, busy);
        end
        do_load(4'd0, 1'b1);
        tests++;
        if ({cnt, tc, busy, done} !== 7'b0) begin
            fails++;
            $display("FAIL coll_load0 got cnt=%0d tc=%b busy=%b done=%b want 0 0 0 0",
                     cnt, tc, busy, done);
        end
        repeat (3) tick();
        tests++;
        if ({cnt, tc, busy, done} !== 7'b0) begin
            fails++;
            $display("FAIL coll_idle got cnt=%0d tc=%b busy=%b done=%b want 0 0 0 0",
                     cnt, tc, busy, done);
        end
        en = 1'b0;
    endtask

    task automatic test_max();
        int tcs = 0;
        do_load(4'd15, 1'b0);
        en = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (tc === 1'b1) tcs++;
            tests++;
            if (cnt !== ((i < 15) ? 4'(15 - i) : 4'd0)) begin
                fails++;
                $display("FAIL max_step%0d got cnt=%0d want %0d",
                         i, cnt, (i < 15) ? 15 - i : 0);
            end
        end
        tests++;
        if (tcs != 1) begin
            fails++;
            $display("FAIL max_tccount got %0d want 1", tcs);
        end
        en = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] m_cnt = 4'd0, m_rv = 4'd0, n_cnt;
        logic       m_mode = 1'b0, m_run = 1'b0, m_done = 1'b0, m_tc = 1'b0;
        int         shown = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            load = ($urandom_range(0, 11) == 0);
            load_val = 4'($urandom_range(0, 15));
            reload = 1'($urandom_range(0, 1));
            en = 1'($urandom_range(0, 2) != 0);
            tick();
            m_tc = 1'b0;
            if (rst) begin
                m_cnt = 0; m_rv = 0; m_mode = 0; m_run = 0; m_done = 0;
            end else if (load) begin
                m_cnt = load_val; m_rv = load_val; m_mode = reload;
                m_run = (load_val != 0); m_done = 1'b0;
            end else if (m_run && en) begin
                n_cnt = m_cnt - 4'd1;
                if (n_cnt == 0) begin
                    m_tc = 1'b1;
                    m_cnt = m_mode ? m_rv : 4'd0;
                    m_run = m_mode;
                    m_done = !m_mode;
                end else begin
                    m_cnt = n_cnt;
                end
            end
            tests++;
            if (cnt !== m_cnt || tc !== m_tc || busy !== m_run || done !== m_done) begin
                fails++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL rand_c%0d got cnt=%0d tc=%b busy=%b done=%b want %0d %b %b %b",
                             c, cnt, tc, busy, done, m_cnt, m_tc, m_run, m_done);
                end
            end
        end
        rst = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_autoreload();
        test_en_gaps();
        test_collision();
        test_max();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/down_counter4b.md
# down_counter4b

Loadable 4-bit down-counter/timer. It is the count-down companion to the team's free-running up counter. Software or a controlling FSM loads a start value, and the block decrements on enabled cycles. It emits a single-cycle terminal-count pulse, then either stops (one-shot) or reloads (auto-reload). It sits beside the up counter as the interval/timeout source for later blocks.

## Interface
- WIDTH, 4, counter width in bits; must be ≥ 2.
- clk  input  1  rising-edge clock.
- rst  input  1  reset.
- load  input  1  load request; sampled each clk edge.
- load_val  input  WIDTH  start value; sampled only when load=1.
- reload  input  1  mode; sampled only when load=1. 1 = auto-reload, 0 = one-shot.
- en  input  1  count enable.
- cnt  output  WIDTH  current count (registered).
- tc  output  1  terminal-count pulse (registered, one cycle).
- busy  output  1  high while in RUN (registered/state-decoded).
- done  output  1  high while in DONE (state-decoded).
- One clock. Reset is synchronous and active-high; ports are named clk and rst.

## Operation
- Internal registers: state {IDLE, RUN, DONE}, cnt, reload_r (WIDTH), mode_r (1).
- Reset (rst=1 at a clk edge) overrides everything:
  - state=IDLE, cnt=0, reload_r=0, mode_r=0, tc=0.
  - Hence busy=0, done=0.
- Priority at every edge: rst > load > en.
- load=1 (any state):
  - reload_r←load_val, mode_r←reload, cnt←load_val, tc←0.
  - load_val≠0 → state=RUN.
  - load_val=0 → state=IDLE. No tc is generated.
- RUN, load=0, en=0: hold cnt; tc←0.
- RUN, load=0, en=1, cnt>1: cnt←cnt−1; tc←0.
- RUN, load=0, en=1, cnt=1 (terminal count): tc←1.
  - mode_r=1: cnt←reload_r; stay RUN.
  - mode_r=0: cnt←0; state=DONE.
- IDLE / DONE, load=0:
  - cnt holds; tc←0.
  - en is ignored.
  - The block leaves these states only via load.
- Arithmetic: unsigned, modulo 2^WIDTH. Underflow below 0 is unreachable by construction, and no wrap to all-ones may ever occur.
- tc is never high for two consecutive cycles unless reload_r=1 in auto-reload mode with en held. In that case tc is high every cycle, which is legal.

## Timing
- Load latency: cnt shows load_val on the edge that samples load=1. busy/done reflect the new state on the same edge.
- en on the load cycle is ignored. The first decrement occurs on the first later edge with en=1.
- One-shot period with en held continuously:
  - Load value N gives cnt = N, N−1, …, 1, 0.
  - tc is high on the same cycle cnt first reads 0, i.e. N edges after the load edge.
- Auto-reload period with en held: tc every N edges; cnt sequence N … 1, N … 1.
- Gaps in en stretch the period cycle-for-cycle; count state is preserved.
- Simultaneous load and terminal count: load wins, tc stays 0, the new value is taken.
- rst mid-run: all outputs return to reset values on that edge, and the pending tc is suppressed.
- mode and start value change only at load. Toggling reload or load_val at other times has no effect.

## Test plan
- Reset: assert rst 2 cycles mid-count → cnt=0, tc=0, busy=0, done=0 on the first edge with rst=1.
- One-shot: load_val=5, reload=0, en held → cnt 5,4,3,2,1,0. tc=1 only on the cycle cnt=0, then done=1 and busy=0. cnt stays 0 for 10 further en cycles.
- Auto-reload: load_val=3, reload=1, en held → cnt 3,2,1,3,2,1,…; tc pulses exactly every 3 cycles; busy stays 1. Also cover load_val=1 → tc every cycle, cnt stays 1.
- Enable gaps: load_val=4, en pattern 1,0,0,1,1,0,1 → cnt 4,3,3,3,2,1,1,0 with tc on the final edge; tc=0 throughout the gap cycles.
- Collision: with cnt=1 and en=1, assert load=1, load_val=9 → cnt=9, tc=0, busy=1. Then load_val=0 with load → cnt=0, state IDLE, busy=0, done=0, tc=0.
- Max value: load_val=15 one-shot → 15 decrements to 0 with no wrap; tc once. Random en/load stimulus is checked against a reference model for 10k cycles.
